// File: rtl/emmc_ddr_rx_ctrl_if.sv
// emmc_ddr_rx_ctrl_if: request, capture-cell and result signals of the eMMC
// DDR receive sequencer. The slave modport is the sequencer; the master modport
// is the side that drives start/config and the IDDR Q outputs.
interface emmc_ddr_rx_ctrl_if #(
    parameter int TIMEOUT_W = 24,
    parameter int LEN_W     = 10
);
    logic                 start;
    logic                 bus_w8;
    logic [LEN_W-1:0]     blk_len;
    logic [TIMEOUT_W-1:0] timeout_cyc;
    logic [7:0]           q_rise;
    logic [7:0]           q_fall;
    logic                 iddr_ce;
    logic                 iddr_rst;
    logic                 busy;
    logic [15:0]          data_word;
    logic                 data_valid;
    logic                 done;
    logic                 crc_err;
    logic                 end_err;
    logic                 timeout;

    modport master (
        output start, bus_w8, blk_len, timeout_cyc, q_rise, q_fall,
        input  iddr_ce, iddr_rst, busy, data_word, data_valid, done,
               crc_err, end_err, timeout
    );

    modport slave (
        input  start, bus_w8, blk_len, timeout_cyc, q_rise, q_fall,
        output iddr_ce, iddr_rst, busy, data_word, data_valid, done,
               crc_err, end_err, timeout
    );
endinterface

// File: rtl/emmc_ddr_rx_ctrl.sv
// emmc_ddr_rx_ctrl: DDR52 block-read sequencer for the DAT-line IDDR bank.
// Arms/clears the capture cells, finds the start bit, packs rise/fall samples
// into 16-bit words (even byte low), checks end bit and, when the macro
// EMMC_DDR_CRC_CHECK_EN is defined, per-line per-edge CRC16.
module emmc_ddr_rx_ctrl #(
    parameter int TIMEOUT_W = 24,
    parameter int LEN_W     = 10
) (
    input  logic              C_i,
    input  logic              R_i,
    emmc_ddr_rx_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, WAIT_START, DATA, CRC, ENDB, FIN} state_t;

    state_t               state_q, state_d;
    logic                 w8_q, w8_d;
    logic [LEN_W-2:0]     hlen_q, hlen_d;     // block length in 16-bit words
    logic [LEN_W-1:0]     cnt_q, cnt_d;       // DATA / CRC cycle counter
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [7:0]           hi_q, hi_d;         // 4-bit mode: {odd[7:4], even[7:4]}
    logic [15:0]          word_q, word_d;
    logic                 dv_q, dv_d;
    logic                 tpulse_q, tpulse_d;
    logic                 end_err_q, end_err_d;

    logic [7:0]           act_mask;
    logic [LEN_W-1:0]     data_last;
    logic [TIMEOUT_W-1:0] tmo_nxt;
    logic                 crc_bad;
    logic                 unused_len_lsb;

    assign unused_len_lsb = bus.blk_len[0];
    assign act_mask  = w8_q ? 8'hFF : 8'h0F;
    assign data_last = w8_q ? {1'b0, hlen_q} - 1'b1 : {hlen_q, 1'b0} - 1'b1;
    assign tmo_nxt   = tmo_q + 1'b1;

    // Next-state and datapath: sequencing, word assembly, timeout and end bit.
    always_comb begin
        state_d   = state_q;
        w8_d      = w8_q;
        hlen_d    = hlen_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        hi_d      = hi_q;
        word_d    = word_q;
        dv_d      = 1'b0;
        tpulse_d  = 1'b0;
        end_err_d = end_err_q;
        case (state_q)
            IDLE: begin
                if (bus.start && bus.blk_len[LEN_W-1:1] != '0) begin
                    state_d = ARM;
                    w8_d    = bus.bus_w8;
                    hlen_d  = bus.blk_len[LEN_W-1:1];
                end
            end
            ARM: begin
                cnt_d     = '0;
                tmo_d     = '0;
                end_err_d = 1'b0;
                state_d   = WAIT_START;
            end
            WAIT_START: begin
                tmo_d = tmo_nxt;
                if ((bus.q_rise & act_mask) == 8'h00) begin
                    state_d = DATA;
                end else if (bus.timeout_cyc != '0 && tmo_nxt == bus.timeout_cyc) begin
                    state_d  = IDLE;
                    tpulse_d = 1'b1;
                end
            end
            DATA: begin
                if (w8_q) begin
                    word_d = {bus.q_fall, bus.q_rise};
                    dv_d   = 1'b1;
                end else if (!cnt_q[0]) begin
                    hi_d = {bus.q_fall[3:0], bus.q_rise[3:0]};
                end else begin
                    word_d = {hi_q[7:4], bus.q_fall[3:0], hi_q[3:0], bus.q_rise[3:0]};
                    dv_d   = 1'b1;
                end
                if (cnt_q == data_last) begin
                    cnt_d   = '0;
                    state_d = CRC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CRC: begin
                if (cnt_q == LEN_W'(15)) state_d = ENDB;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            ENDB: begin
                end_err_d = |(~bus.q_rise & act_mask);
                state_d   = FIN;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any block in flight.
    always_ff @(posedge C_i) begin
        if (R_i) begin
            state_q   <= IDLE;
            w8_q      <= 1'b0;
            hlen_q    <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            hi_q      <= '0;
            word_q    <= '0;
            dv_q      <= 1'b0;
            tpulse_q  <= 1'b0;
            end_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            w8_q      <= w8_d;
            hlen_q    <= hlen_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            hi_q      <= hi_d;
            word_q    <= word_d;
            dv_q      <= dv_d;
            tpulse_q  <= tpulse_d;
            end_err_q <= end_err_d;
        end
    end

`ifdef EMMC_DDR_CRC_CHECK_EN
    logic [7:0][15:0] crc_r_q, crc_r_d, crc_f_q, crc_f_d;
    logic             crc_err_q, crc_err_d;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // Each register runs over its data bits and then the received CRC bits;
    // a correct CRC leaves the remainder at zero after the last CRC bit.
    always_comb begin
        crc_r_d   = crc_r_q;
        crc_f_d   = crc_f_q;
        crc_err_d = crc_err_q;
        if (state_q == ARM) begin
            crc_r_d   = '0;
            crc_f_d   = '0;
            crc_err_d = 1'b0;
        end else if (state_q == DATA || state_q == CRC) begin
            for (int i = 0; i < 8; i++) begin
                crc_r_d[i] = crc16_step(crc_r_q[i], bus.q_rise[i]);
                crc_f_d[i] = crc16_step(crc_f_q[i], bus.q_fall[i]);
            end
            if (state_q == CRC && cnt_q == LEN_W'(15)) begin
                crc_err_d = 1'b0;
                for (int i = 0; i < 8; i++)
                    if (act_mask[i] && (crc_r_d[i] != '0 || crc_f_d[i] != '0))
                        crc_err_d = 1'b1;
            end
        end
    end

    // CRC remainder and result registers.
    always_ff @(posedge C_i) begin
        if (R_i) begin
            crc_r_q   <= '0;
            crc_f_q   <= '0;
            crc_err_q <= 1'b0;
        end else begin
            crc_r_q   <= crc_r_d;
            crc_f_q   <= crc_f_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_bad = crc_err_q;
`else
    assign crc_bad = 1'b0;
`endif

    assign bus.busy       = (state_q != IDLE);
    assign bus.iddr_ce    = state_q inside {ARM, WAIT_START, DATA, CRC, ENDB};
    assign bus.iddr_rst   = R_i || (state_q == ARM);
    assign bus.data_word  = word_q;
    assign bus.data_valid = dv_q;
    assign bus.done       = (state_q == FIN);
    assign bus.crc_err    = (state_q == FIN) && crc_bad;
    assign bus.end_err    = (state_q == FIN) && end_err_q;
    assign bus.timeout    = tpulse_q;
endmodule

// File: tb/tb_emmc_ddr_rx_ctrl.sv
// tb_emmc_ddr_rx_ctrl: directed blocks with hand-picked data; expected words,
// done flags and timeouts go into queues that a negedge monitor drains.
module tb_emmc_ddr_rx_ctrl;
`ifdef EMMC_DDR_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    logic [15:0] exp_words[$];
    logic [1:0]  exp_done[$];   // {crc_err, end_err}
    int          exp_tmo = 0;

    emmc_ddr_rx_ctrl_if #(.TIMEOUT_W(24), .LEN_W(10)) bus ();

    emmc_ddr_rx_ctrl #(.TIMEOUT_W(24), .LEN_W(10)) dut (
        .C_i (clk),
        .R_i (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        nvec++;
        nerr++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Present one rise/fall pair across exactly one posedge.
    task automatic step(input logic [7:0] r, input logic [7:0] f);
        bus.q_rise = r;
        bus.q_fall = f;
        @(negedge clk);
    endtask

    // Monitor: compare every output event against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.data_valid) begin
                if (exp_words.size() == 0) flag("unexpected_word", bus.data_word);
                else chk("word", bus.data_word, exp_words.pop_front());
            end
            if (bus.done) begin
                if (exp_done.size() == 0) flag("unexpected_done", {bus.crc_err, bus.end_err});
                else begin
                    logic [1:0] e;
                    e = exp_done.pop_front();
                    chk("crc_err", bus.crc_err, e[1]);
                    chk("end_err", bus.end_err, e[0]);
                end
            end else begin
                chk("flags_outside_fin", {bus.crc_err, bus.end_err}, 2'b00);
            end
            if (bus.timeout) begin
                if (exp_tmo == 0) flag("unexpected_timeout", bus.timeout);
                else begin
                    exp_tmo--;
                    chk("busy_at_timeout", bus.busy, 1'b0);
                end
            end
        end
    end

    // Drive one complete block; words for the scoreboard are pushed by the caller.
    task automatic run_block(input bit w8, input logic [9:0] len, input int ncyc,
                             input logic [7:0] rv[8], input logic [7:0] fv[8],
                             input int delay, input int flip_line, input bit flip_fall,
                             input int endbad_line, input bit exp_crc, input bit exp_end);
        logic [15:0] cr[8];
        logic [15:0] cf[8];
        logic [7:0]  m, r, f;
        for (int i = 0; i < 8; i++) begin cr[i] = '0; cf[i] = '0; end
        m = w8 ? 8'hFF : 8'h0F;
        exp_done.push_back({exp_crc, exp_end});
        bus.bus_w8  = w8;
        bus.blk_len = len;
        bus.start   = 1'b1;
        step(8'hFF, 8'hFF);
        bus.start   = 1'b0;
        chk("arm_iddr_rst", bus.iddr_rst, 1'b1);
        chk("arm_busy", bus.busy, 1'b1);
        step(8'hFF, 8'hFF);
        for (int d = 0; d < delay; d++) step(8'hFF, 8'hFF);
        step(~m, 8'hFF);
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < 8; i++) begin
                cr[i] = crc_step(cr[i], rv[c][i]);
                cf[i] = crc_step(cf[i], fv[c][i]);
            end
            step(rv[c], fv[c]);
        end
        chk("last_word_in_crc0", bus.data_valid, 1'b1);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 8; i++) begin
                r[i] = cr[i][15-k];
                f[i] = cf[i][15-k];
            end
            if (k == 5 && flip_line >= 0) begin
                if (flip_fall) f[flip_line] = ~f[flip_line];
                else           r[flip_line] = ~r[flip_line];
            end
            step(r, f);
        end
        chk("endb_done", bus.done, 1'b0);
        chk("endb_ce", bus.iddr_ce, 1'b1);
        r = 8'hFF;
        if (endbad_line >= 0) r[endbad_line] = 1'b0;
        step(r, 8'hFF);
        chk("fin_done", bus.done, 1'b1);
        chk("fin_ce", bus.iddr_ce, 1'b0);
        step(8'hFF, 8'hFF);
        chk("idle_busy", bus.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] rv[8];
        logic [7:0] fv[8];
        int seen;
        bus.start = 1'b0; bus.bus_w8 = 1'b0; bus.blk_len = '0; bus.timeout_cyc = '0;
        bus.q_rise = 8'hFF; bus.q_fall = 8'hFF;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_iddr_rst", bus.iddr_rst, 1'b1);
        chk("rst_iddr_ce", bus.iddr_ce, 1'b0);
        chk("rst_dv", bus.data_valid, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;
        step(8'hFF, 8'hFF);
        chk("iddr_rst_released", bus.iddr_rst, 1'b0);

        // blk_len = 1 has no whole word and is ignored
        bus.blk_len = 10'd1; bus.bus_w8 = 1'b1; bus.start = 1'b1;
        step(8'hFF, 8'hFF);
        bus.start = 1'b0;
        chk("len1_ignored", bus.busy, 1'b0);

        // 8-bit, two words, clean
        rv = '{default: 8'h00}; fv = '{default: 8'h00};
        rv[0] = 8'h11; fv[0] = 8'h22; rv[1] = 8'h33; fv[1] = 8'h44;
        exp_words.push_back(16'h2211); exp_words.push_back(16'h4433);
        run_block(1'b1, 10'd4, 2, rv, fv, 3, -1, 1'b0, -1, 1'b0, 1'b0);

        // 4-bit, one word; upper lines carry junk
        rv[0] = 8'h9A; fv[0] = 8'h75; rv[1] = 8'h23; fv[1] = 8'hEC;
        exp_words.push_back(16'h5CA3);
        bus.timeout_cyc = 24'd1000;
        run_block(1'b0, 10'd2, 2, rv, fv, 0, -1, 1'b0, -1, 1'b0, 1'b0);
        bus.timeout_cyc = '0;

        // case 1 with a CRC bit flipped on DAT5 fall stream
        rv[0] = 8'h11; fv[0] = 8'h22; rv[1] = 8'h33; fv[1] = 8'h44;
        exp_words.push_back(16'h2211); exp_words.push_back(16'h4433);
        run_block(1'b1, 10'd4, 2, rv, fv, 1, 5, 1'b1, -1, CRC_ON, 1'b0);

        // minimum block, end bit low on DAT0
        rv[0] = 8'h5A; fv[0] = 8'hC3;
        exp_words.push_back(16'hC35A);
        run_block(1'b1, 10'd2, 1, rv, fv, 0, -1, 1'b0, 0, 1'b0, 1'b1);

        // start-bit timeout after 10 WAIT_START cycles; a start while busy is ignored
        bus.timeout_cyc = 24'd10; bus.bus_w8 = 1'b1; bus.blk_len = 10'd4;
        exp_tmo++;
        bus.start = 1'b1;
        step(8'hFF, 8'hFF);
        bus.start = 1'b0;
        step(8'hFF, 8'hFF);
        seen = -1;
        for (int k = 0; k < 20; k++) begin
            if (bus.timeout && seen < 0) seen = k;
            bus.start = (k == 3);
            step(8'hFF, 8'hFF);
        end
        bus.start = 1'b0;
        chk("timeout_latency", seen, 10);
        chk("busy_after_timeout", bus.busy, 1'b0);
        bus.timeout_cyc = '0;

        // reset in the middle of DATA
        bus.bus_w8 = 1'b1; bus.blk_len = 10'd8;
        exp_words.push_back(16'h2211); exp_words.push_back(16'h4433);
        bus.start = 1'b1;
        step(8'hFF, 8'hFF);
        bus.start = 1'b0;
        step(8'hFF, 8'hFF);
        step(8'h00, 8'hFF);
        step(8'h11, 8'h22);
        step(8'h33, 8'h44);
        rst = 1'b1;
        step(8'h55, 8'h66);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_dv", bus.data_valid, 1'b0);
        chk("abort_iddr_rst", bus.iddr_rst, 1'b1);
        chk("abort_iddr_ce", bus.iddr_ce, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_word", bus.data_word, 16'h0000);
        rst = 1'b0;
        step(8'hFF, 8'hFF);
        chk("abort_iddr_rst_low", bus.iddr_rst, 1'b0);

        // full 4-bit block after the abort; blk_len=5 treated as 4
        rv = '{default: 8'h00}; fv = '{default: 8'h00};
        rv[0] = 8'h01; fv[0] = 8'h03; rv[1] = 8'h02; fv[1] = 8'h04;
        rv[2] = 8'h0D; fv[2] = 8'h0A; rv[3] = 8'h0E; fv[3] = 8'h0D;
        exp_words.push_back(16'h3412); exp_words.push_back(16'hADDE);
        run_block(1'b0, 10'd5, 4, rv, fv, 2, -1, 1'b0, -1, 1'b0, 1'b0);

        repeat (3) step(8'hFF, 8'hFF);
        chk("words_left", exp_words.size(), 0);
        chk("done_left", exp_done.size(), 0);
        chk("timeouts_left", exp_tmo, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/emmc_ddr_rx_ctrl.md
# emmc_ddr_rx_ctrl

Sequencer for the bank of DDR input-capture cells on the eMMC DAT lines during DDR52 block reads. It arms and clears the capture cells, detects the start bit, and assembles rising- and falling-edge samples into 16-bit words (even byte low, odd byte high). It also checks per-line, per-edge CRC16 and the end bit, and reports completion, errors and start-bit timeout to the data-path FSM. It sits between the IDDR capture bank and the read FIFO write port.

## Interface

Parameters:
- `TIMEOUT_W`, 24: width of the start-bit timeout counter and `timeout_cyc`.
- `LEN_W`, 10: width of `blk_len` in bytes; max block 512.

Ports (one clock; reset is synchronous and active-high):
- `C`  in  1  clock; all logic on posedge.
- `R`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle request to receive one block.
- `bus_w8`  in  1  1 = 8-bit bus (DAT[7:0]), 0 = 4-bit bus (DAT[3:0]); latched on accepted `start`.
- `blk_len`  in  LEN_W  block length in bytes; latched on accepted `start`; bit 0 ignored.
- `timeout_cyc`  in  TIMEOUT_W  start-bit wait limit in cycles; 0 = wait forever.
- `q_rise`  in  8  capture-cell Q1 outputs (rising-edge sample), DAT[7:0].
- `q_fall`  in  8  capture-cell Q2 outputs (falling-edge sample), same cycle as `q_rise`.
- `iddr_ce`  out  1  clock enable to all capture cells.
- `iddr_rst`  out  1  reset to all capture cells.
- `busy`  out  1  high in every state except IDLE.
- `data_word`  out  16  [7:0] even byte, [15:8] odd byte.
- `data_valid`  out  1  one-cycle qualifier for `data_word`; no backpressure.
- `done`  out  1  one-cycle pulse at block end, with or without errors.
- `crc_err`  out  1  valid with `done`.
- `end_err`  out  1  valid with `done`.
- `timeout`  out  1  one-cycle pulse; no `done` follows.

## Operation

- States: IDLE, ARM, WAIT_START, DATA, CRC, ENDB, FIN.
- IDLE: `start` with `blk_len[LEN_W-1:1]` ≠ 0 → ARM. Otherwise `start` is ignored. `start` is ignored in all other states.
- ARM (1 cycle): `iddr_rst`=1, `iddr_ce`=1; clears the cells, CRC registers, byte and cycle counters → WAIT_START.
- Active lines: DAT[7:0] if `bus_w8`, else DAT[3:0]; inactive lines ignored everywhere.
- WAIT_START: start bit = all active bits of `q_rise` are 0; that cycle's `q_fall` is ignored → DATA. The timeout counter increments each cycle. If it reaches `timeout_cyc` (≠ 0) before a start bit → `timeout` pulse, IDLE.
- DATA, 8-bit: one cycle per word; word = {`q_fall[7:0]`, `q_rise[7:0]`}; `blk_len/2` cycles.
- DATA, 4-bit: two cycles per word. The first cycle carries high nibbles (rise → even[7:4], fall → odd[7:4]); the second carries low nibbles; `blk_len` cycles.
- CRC: 16 cycles; captures 16 rise-stream and 16 fall-stream CRC bits per active line.
- ENDB (1 cycle): `end_err` = any active `q_rise` bit is 0 → FIN.
- FIN (1 cycle): `done`=1 with the error flags → IDLE.
- CRC16: polynomial x^16+x^12+x^5+1, init 0, MSB first. There are independent registers per line per edge (up to 16). Each covers that line/edge's DATA bits; a mismatch on any active register sets `crc_err`.
- `iddr_ce`=1 in ARM through ENDB, else 0. `iddr_rst`=1 in ARM or while `R`=1, else 0.

## Timing

- Reset: next posedge → IDLE. All outputs 0 except `iddr_rst`=1 while `R`=1. `R` mid-block aborts with no `done`, `data_valid` or `timeout`.
- `start` accepted at edge N → ARM during N+1, WAIT_START from N+2.
- `data_valid` is registered: asserted the cycle after the last contributing DATA cycle. The final word's `data_valid` therefore coincides with the first CRC cycle.
- CRC comparison completes on the last CRC cycle; `end_err` is registered in ENDB; `done`, `crc_err` and `end_err` are driven in FIN, 2 cycles after the last CRC cycle.
- `crc_err` and `end_err` are 0 outside FIN.
- `timeout` is asserted the cycle after the counter matches; `busy` drops the same cycle.
- Minimum block (`blk_len`=2, 8-bit): `start` to `done` = 1+1+1(start)+1+16+1+1 cycles with an immediate start bit.

## Configuration

- `EMMC_DDR_CRC_CHECK_EN` defined: CRC registers and comparison are built as above.
- `EMMC_DDR_CRC_CHECK_EN` undefined: no CRC registers. The CRC state still spends its 16 cycles discarding the bits. `crc_err` is tied 0.

## Test plan

- 8-bit, `blk_len`=4; rise/fall pairs 0x11/0x22, 0x33/0x44; correct CRC and end bit → words 0x2211, 0x4433, then `done`=1 with `crc_err`=0 and `end_err`=0.
- 4-bit, `blk_len`=2; cycle 1 rise/fall nibbles 0xA/0x5, cycle 2 0x3/0xC → single word 0x5CA3, one `data_valid`, clean `done`.
- Same as case 1 with one CRC bit flipped on DAT5 fall stream → `done` with `crc_err`=1 (0 when the macro is undefined); data words unchanged.
- End bit 0 on DAT0 → `done` with `end_err`=1.
- `timeout_cyc`=10, DAT held high → `timeout` pulse after 10 WAIT_START cycles, no `done`, `busy`=0 after the pulse. A second `start` while busy is ignored.
- `R` asserted mid-DATA → next cycle IDLE, all outputs 0, `iddr_rst`=1. A subsequent `start` receives a full block correctly.
